// File: rtl/dma_buffer_reader_pkg.sv
// dma_buffer_reader_pkg
//   Shared types and width helpers for the DMA buffer read initiator.
//   state_t    : reader FSM states
//   addr_width : address width for a given buffer depth (at least 1)
//   len_width  : burst-length width, wide enough to hold the full depth
package dma_buffer_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int addr_width(input int entries);
      return (entries > 2) ? $clog2(entries) : 1;
   endfunction

   function automatic int len_width(input int entries);
      return addr_width(entries) + 1;
   endfunction

endpackage

// File: rtl/dma_buffer_reader_fifo.sv
// stream_fifo2
//   Two-entry registered FIFO that decouples RAM read data from the
//   downstream handshake.
//   clock, reset : clock, async active-high reset
//   push         : write pushData this cycle
//   pop          : drop the head entry this cycle
//   pushData     : incoming word
//   headData     : oldest stored word
//   full, empty  : occupancy flags
//   count        : number of stored words (0..2)
// The caller never pushes into a full FIFO unless it pops in the same
// cycle, and never pops an empty one.
module stream_fifo2 #(
   parameter int width = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] pushData,
   output logic [width-1:0] headData,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [width-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= pushData;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign headData = mem[rd_ptr];
   assign full     = (count == 2'd2);
   assign empty    = (count == 2'd0);

endmodule

// File: rtl/dma_buffer_reader.sv
// dma_buffer_reader
//   Issues sequential reads on one port of the DMA buffer RAM and delivers
//   the words as a valid/ready stream. Addresses wrap modulo the depth.
//   clock, reset     : clock, async active-high reset
//   start            : command pulse, taken only while idle
//   startAddress     : first entry to read
//   burstLength      : number of words (0..nrOfEntries)
//   busy, done       : burst in progress / one-cycle completion pulse
//   memAddress       : RAM read address
//   memWriteEnable   : always 0
//   memDataIn        : RAM read data, one cycle after the address
//   streamData/Valid : output word and its valid flag
//   streamReady      : downstream accept
//
// state | meaning
// IDLE  | waiting for start; done is high here for one cycle after a burst
// READ  | issuing reads, at most two words outstanding ahead of the stream
// DRAIN | all reads issued, waiting for the last word to be accepted
module dma_buffer_reader
   import dma_buffer_reader_pkg::*;
#(
   parameter  int bitwidth    = 32,
   parameter  int nrOfEntries = 512,
   localparam int AW          = addr_width(nrOfEntries),
   localparam int LW          = len_width(nrOfEntries)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [AW-1:0]       startAddress,
   input  logic [LW-1:0]       burstLength,
   output logic                busy,
   output logic                done,
   output logic [AW-1:0]       memAddress,
   output logic                memWriteEnable,
   input  logic [bitwidth-1:0] memDataIn,
   output logic [bitwidth-1:0] streamData,
   output logic                streamValid,
   input  logic                streamReady
);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_inc;
   logic [LW-1:0] issue_cnt;
   logic [LW-1:0] out_cnt;
   logic          in_flight;
   logic          issue;
   logic          load;
   logic          done_nxt;
   logic          pop;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic [1:0]    fifo_count;
   logic [2:0]    occupancy;

   assign pop       = streamValid & streamReady;
   // A pushed word never finds the FIFO full unless the head leaves
   // in the same cycle; the issue gate below keeps it that way.
   assign push      = in_flight & (~fifo_full | pop);
   assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight};
   assign addr_inc  = (addr == AW'(nrOfEntries - 1)) ? '0 : addr + AW'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      load      = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (burstLength != '0) begin
                  load      = 1'b1;
                  state_nxt = READ;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         READ: begin
            // words held or in flight after this cycle's pop must stay below 2
            issue = (occupancy < (3'd2 + {2'b00, pop}));
            if (issue && (issue_cnt == LW'(1))) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (out_cnt == LW'(1))) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         issue_cnt <= '0;
         out_cnt   <= '0;
         in_flight <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= done_nxt;
         in_flight <= issue;
         if (load) begin
            addr      <= startAddress;
            issue_cnt <= burstLength;
            out_cnt   <= burstLength;
         end else begin
            if (issue) begin
               addr      <= addr_inc;
               issue_cnt <= issue_cnt - LW'(1);
            end
            if (pop) begin
               out_cnt <= out_cnt - LW'(1);
            end
         end
      end
   end

   stream_fifo2 #(
      .width (bitwidth)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .pushData (memDataIn),
      .headData (streamData),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign streamValid    = ~fifo_empty;
   assign busy           = (state != IDLE);
   assign memAddress     = addr;
   assign memWriteEnable = 1'b0;

endmodule

// File: tb/tb_dma_buffer_reader.sv
module tb_dma_buffer_reader;

   localparam int NE = 512;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [8:0]  startAddress;
   logic [9:0]  burstLength;
   logic        busy;
   logic        done;
   logic [8:0]  memAddress;
   logic        memWriteEnable;
   logic [31:0] memDataIn;
   logic [31:0] streamData;
   logic        streamValid;
   logic        streamReady;

   logic [31:0] ram [NE];

   int checks   = 0;
   int failures = 0;

   int neg_count = 0;
   int base      = 0;

   logic [31:0] got_q [$];
   int          got_cyc [$];
   int          done_cnt;
   int          done_cyc;
   logic        done_busy;
   int          issues;
   int          pops;
   int          max_ahead;
   int          unstable;
   int          valid_cycles;
   int          we_high = 0;
   logic        stall_prev;
   logic [31:0] stall_data;
   logic [8:0]  prev_addr;
   bit          ready_pat [3] = '{1'b1, 1'b0, 1'b0};

   dma_buffer_reader #(
      .bitwidth    (32),
      .nrOfEntries (NE)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .startAddress   (startAddress),
      .burstLength    (burstLength),
      .busy           (busy),
      .done           (done),
      .memAddress     (memAddress),
      .memWriteEnable (memWriteEnable),
      .memDataIn      (memDataIn),
      .streamData     (streamData),
      .streamValid    (streamValid),
      .streamReady    (streamReady)
   );

   always #5 clock = ~clock;

   // registered-read RAM port
   always @(posedge clock) memDataIn <= ram[memAddress];

   always @(negedge clock) begin
      neg_count = neg_count + 1;
      if (!reset) begin
         if (memWriteEnable) we_high = we_high + 1;
         if (memAddress != prev_addr) begin
            issues    = issues + 1;
            prev_addr = memAddress;
         end
         if (issues - pops > max_ahead) max_ahead = issues - pops;
         if (stall_prev && !(streamValid && streamData == stall_data)) unstable = unstable + 1;
         stall_prev = streamValid && !streamReady;
         stall_data = streamData;
         if (streamValid) valid_cycles = valid_cycles + 1;
         if (streamValid && streamReady) begin
            got_q.push_back(streamData);
            got_cyc.push_back(neg_count - base);
            pops = pops + 1;
         end
         if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = neg_count - base;
            done_busy = busy;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_addr"}, memAddress, 0);
      check_eq({tag, "_we"}, memWriteEnable, 0);
      check_eq({tag, "_data"}, streamData, 0);
      check_eq({tag, "_valid"}, streamValid, 0);
   endtask

   task automatic launch(input int sa, input int len);
      @(posedge clock); #1;
      startAddress = 9'(sa);
      burstLength  = 10'(len);
      start        = 1'b1;
      @(posedge clock);
      base         = neg_count;
      got_q.delete();
      got_cyc.delete();
      done_cnt     = 0;
      done_cyc     = -1;
      done_busy    = 1'b1;
      issues       = 0;
      pops         = 0;
      max_ahead    = 0;
      unstable     = 0;
      valid_cycles = 0;
      stall_prev   = 1'b0;
      prev_addr    = 9'(sa);
      #1;
      start = 1'b0;
      check_eq("launch_busy", busy, (len != 0));
      if (len != 0) check_eq("launch_addr", memAddress, sa);
   endtask

   task automatic wait_done(input string tag, input int budget, input bit bp);
      int i;
      i = 0;
      while (done_cnt == 0 && i < budget) begin
         @(posedge clock); #1;
         i = i + 1;
         if (bp) streamReady = ready_pat[(neg_count - base) % 3];
      end
      check_eq({tag, "_done_seen"}, (done_cnt != 0), 1);
      streamReady = 1'b1;
      repeat (4) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic check_burst(input string tag, input int sa, input int n,
                              input int first_cyc, input int done_at);
      logic [31:0] w;
      int          c;
      check_eq({tag, "_count"}, got_q.size(), n);
      for (int i = 0; i < n; i++) begin
         w = (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx;
         check_eq($sformatf("%s_w%0d", tag, i), w, 32'hC0DE_0000 | 32'((sa + i) % NE));
         if (first_cyc > 0) begin
            c = (i < got_cyc.size()) ? got_cyc[i] : -1;
            check_eq($sformatf("%s_c%0d", tag, i), c, first_cyc + i);
         end
      end
      check_eq({tag, "_done_cnt"}, done_cnt, 1);
      if (done_at > 0) check_eq({tag, "_done_cyc"}, done_cyc, done_at);
      check_eq({tag, "_busy_at_done"}, done_busy, 0);
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      startAddress = '0;
      burstLength  = '0;
      streamReady  = 1'b1;
      for (int i = 0; i < NE; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
      prev_addr    = '0;
      issues       = 0;
      pops         = 0;
      done_cnt     = 0;
      stall_prev   = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check_idle_outputs("rst");
      reset = 1'b0;
      @(posedge clock); #1;
      check_idle_outputs("post_rst");

      // basic: 4 words from entry 5, ready held high
      launch(5, 4);
      wait_done("basic", 40, 1'b0);
      check_burst("basic", 5, 4, 3, 7);
      check_eq("basic_valid_cycles", valid_cycles, 4);

      // wrap past the last entry
      launch(510, 4);
      wait_done("wrap", 40, 1'b0);
      check_burst("wrap", 510, 4, 3, 7);

      // backpressure with ready pattern 1,0,0
      launch(20, 6);
      wait_done("bp", 100, 1'b1);
      check_burst("bp", 20, 6, 0, 0);
      check_eq("bp_stable", unstable, 0);
      check_eq("bp_max_ahead", max_ahead, 2);

      // zero-length burst
      launch(77, 0);
      wait_done("zero", 20, 1'b0);
      check_burst("zero", 77, 0, 0, 1);
      check_eq("zero_valid_cycles", valid_cycles, 0);

      // full-depth burst starting mid-buffer
      launch(300, 512);
      wait_done("full", 700, 1'b0);
      check_burst("full", 300, 512, 3, 515);

      // start while busy is ignored
      launch(40, 5);
      @(posedge clock); #1;
      startAddress = 9'd200;
      burstLength  = 10'd3;
      start        = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done("busy_start", 40, 1'b0);
      check_burst("busy_start", 40, 5, 3, 8);
      check_eq("busy_start_idle", busy, 0);

      // reset in cycle 4 of an 8-word burst
      launch(60, 8);
      repeat (3) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      check_idle_outputs("mid_rst");
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
      end
      check_eq("mid_rst_no_done", done_cnt, 0);
      check_eq("mid_rst_no_valid", streamValid, 0);
      launch(100, 3);
      wait_done("after_rst", 40, 1'b0);
      check_burst("after_rst", 100, 3, 3, 6);

      check_eq("we_never", we_high, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_buffer_reader.md
# dma_buffer_reader

Read-side initiator for the DMA module's dual-port buffer RAM. On a start command it issues sequential reads on one RAM port, absorbing the RAM's one-cycle registered read latency. It delivers the words as a valid/ready stream toward the bus-master side. Addresses wrap modulo the buffer depth, so ring-buffer transfers need no special handling.

## Interface
Parameters:
- bitwidth, 32, word width of the buffer and the stream
- nrOfEntries, 512, buffer depth; AW = $clog2(nrOfEntries)

Ports:
- clock  input  1  single clock for all logic
- reset  input  1  asynchronous, active-high
- start  input  1  command pulse; sampled only while busy = 0
- startAddress  input  AW  first buffer entry to read
- burstLength  input  AW+1  number of words, 0..nrOfEntries
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the burst completes
- memAddress  output  AW  RAM port address
- memWriteEnable  output  1  tied 0; this block never writes
- memDataIn  input  bitwidth  RAM port read data, valid one cycle after address
- streamData  output  bitwidth  output word
- streamValid  output  1  streamData valid
- streamReady  input  1  downstream accepts the word when valid and ready are both high

## Operation
- Reset values: busy 0, done 0, memAddress 0, memWriteEnable 0, streamData 0, streamValid 0. The reset clears the FSM, counters, in-flight flag and FIFO.
- FSM states:
  - IDLE: start && burstLength != 0 loads addr = startAddress, issueCnt = burstLength, outCnt = burstLength, then goes to READ. start && burstLength == 0 goes to IDLE, pulses done the next cycle, and emits no data.
  - READ: issues reads. When issueCnt reaches 0, goes to DRAIN.
  - DRAIN: waits for the last word to be accepted. When outCnt reaches 0, goes to IDLE with done = 1 for that one cycle.
- Read issue in READ:
  - A read issues in a cycle when (fifoCount + inFlight − pop) < 2, where pop = streamValid && streamReady.
  - On issue: addr increments and wraps from nrOfEntries−1 to 0; issueCnt decrements; inFlight is set for the next cycle.
  - memAddress = addr at all times. It holds its value when no read issues; a stale re-read is harmless because inFlight gates capture.
- Capture: if inFlight, memDataIn is pushed into the 2-entry FIFO at the next edge. The push condition guarantees the FIFO never overflows.
- Output: streamValid = FIFO not empty; streamData = FIFO head. Each pop decrements outCnt.
- start while busy is ignored. There is no abort; only reset terminates a burst.
- Reset mid-burst: everything returns to reset values immediately. Partial data is discarded and no done pulse is produced.

## Timing
- Start sampled at edge E0:
  - busy = 1 and the first memAddress = startAddress in cycle 1.
  - Data arrives on memDataIn in cycle 2 and is captured at the end of cycle 2.
  - streamValid = 1 in cycle 3.
- With streamReady held high, throughput is 1 word/cycle. A burst of N words completes its last handshake in cycle N+2.
- done pulses in cycle N+3; busy falls in that same cycle.
- streamReady low: at most two words are buffered and issue stalls. streamValid and streamData stay stable until accepted.
- Back-to-back: a new start is accepted in the cycle done is high, since busy = 0 then.

## Structure
- Shared package dma_buffer_reader_pkg holds:
  - the state enum {IDLE, READ, DRAIN}
  - the AW and length-width derivation functions
- Sub-module stream_fifo2: 2-entry registered FIFO with push/pop, full/empty and a 2-bit count. It has the same clock and async active-high reset.

## Test plan
- Basic: startAddress 5, burstLength 4, RAM preloaded with data = address, streamReady = 1 -> stream 5,6,7,8 in cycles 3..6; done in cycle 7; memWriteEnable always 0.
- Wrap: nrOfEntries 512, startAddress 510, burstLength 4 -> words from entries 510, 511, 0, 1 in order.
- Backpressure: burstLength 6 with streamReady toggling 1,0,0,1,… -> no loss or duplication; streamData stable while stalled; at most 2 issues ahead of pops.
- Edge lengths: burstLength 0 -> done pulse at cycle 1, streamValid never rises; burstLength 512 -> all 512 entries read once.
- Start while busy: start pulse mid-burst with different parameters -> ignored; the original burst completes unchanged.
- Reset mid-burst: assert reset at cycle 4 of an 8-word burst -> all outputs 0 immediately; a new start after reset streams correctly from its own startAddress.
